// File: rtl/axis_sa_dw_if.sv
// Stream bundle for axis_sa_dw: one valid/ready/last/data channel of LANES x WY bits.
// The block uses one instance per side (R lanes in, M lanes out).
interface axis_sa_dw_if #(
  parameter int LANES = 4,
  parameter int WY    = 16
);
  logic                  valid;
  logic                  ready;
  logic                  last;
  logic [LANES*WY-1:0]   data;

  modport master (output valid, output last, output data, input ready);
  modport slave  (input valid, input last, input data, output ready);
endinterface

// File: rtl/axis_sa_dw.sv
// Width downconverter: splits each R-lane beat into N = R/M sub-beats of M lanes.
// Optional macro AXIS_SA_DW_RELU_EN clamps negative output lanes to zero.
module axis_sa_dw #(
  parameter int R  = 4,
  parameter int WY = 16,
  parameter int M  = 2
) (
  input  logic         clk,
  input  logic         rst,
  axis_sa_dw_if.slave  s,
  axis_sa_dw_if.master m
);
  // R must be an integer multiple of M.
  localparam int N  = R / M;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [R*WY-1:0]   data_reg;
  logic              last_reg;
  logic              load;
  logic              full;
  logic              last_sub;
  logic              s_ready_int;
  logic              in_hs;
  logic              out_hs;
  logic [M*WY-1:0]   sub_sel;
  logic [M*WY-1:0]   out_data;

  assign full        = (state_reg == HOLD);
  assign last_sub    = (cnt_reg == CNT_LAST);
  // Refill is allowed in the same cycle the final sub-beat leaves.
  assign s_ready_int = !full || (last_sub && m.ready);
  assign in_hs       = s.valid && s_ready_int;
  assign out_hs      = full && m.ready;

  assign s.ready = s_ready_int;
  assign m.valid = full;
  assign m.last  = full && last_reg && last_sub;
  assign m.data  = out_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (in_hs) begin
          state_next = HOLD;
          cnt_next   = '0;
          load       = 1'b1;
        end
      end
      HOLD: begin
        if (out_hs) begin
          if (!last_sub) begin
            cnt_next = cnt_reg + CW'(1);
          end else if (in_hs) begin
            cnt_next = '0;
            load     = 1'b1;
          end else begin
            state_next = EMPTY;
            cnt_next   = '0;
          end
        end
      end
      default: begin
        state_next = EMPTY;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg <= '0;
      last_reg <= 1'b0;
    end else if (load) begin
      data_reg <= s.data;
      last_reg <= s.last;
    end
  end

  // Sub-beat select as an AND-OR mux, one term per sub-beat position.
  logic [M*WY-1:0] sub_or [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi = gi + 1) begin : g_sub
      logic [M*WY-1:0] masked;
      assign masked = (cnt_reg == CW'(gi)) ? data_reg[gi*M*WY +: M*WY] : '0;
      if (gi == 0) begin : g_first
        assign sub_or[gi] = masked;
      end else begin : g_rest
        assign sub_or[gi] = sub_or[gi-1] | masked;
      end
    end
  endgenerate

  assign sub_sel = sub_or[N-1];

  generate
    for (gi = 0; gi < M; gi = gi + 1) begin : g_lane
`ifdef AXIS_SA_DW_RELU_EN
      logic [WY-1:0] lane;
      assign lane = sub_sel[gi*WY +: WY];
      assign out_data[gi*WY +: WY] = lane[WY-1] ? '0 : lane;
`else
      assign out_data[gi*WY +: WY] = sub_sel[gi*WY +: WY];
`endif
    end
  endgenerate

endmodule

// File: tb/tb_axis_sa_dw.sv
// Scoreboard bench for axis_sa_dw (R=4, M=2, WY=16): driver pushes expected
// sub-beats on each accepted input beat, a monitor pops and compares on output handshakes.
module tb_axis_sa_dw;
  localparam int R  = 4;
  localparam int M  = 2;
  localparam int WY = 16;

  logic clk;
  logic rst;

  axis_sa_dw_if #(.LANES(R), .WY(WY)) s_if ();
  axis_sa_dw_if #(.LANES(M), .WY(WY)) m_if ();

  axis_sa_dw #(.R(R), .WY(WY), .M(M)) dut (
    .clk (clk),
    .rst (rst),
    .s   (s_if),
    .m   (m_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   in_lasts = 0;
  int   out_lasts = 0;
  bit   rand_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] relu2(input logic [31:0] x);
    logic [31:0] y;
    y = x;
`ifdef AXIS_SA_DW_RELU_EN
    if (x[15]) y[15:0]  = 16'h0000;
    if (x[31]) y[31:16] = 16'h0000;
`endif
    return y;
  endfunction

  // Drive one beat starting just after a rising edge; returns at posedge+1 after acceptance.
  task automatic send_beat(input logic [63:0] d, input logic l);
    bit ok;
    ok = 0;
    s_if.valid = 1'b1;
    s_if.data  = d;
    s_if.last  = l;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (s_if.ready) begin
        ok = 1;
        q.push_back('{data: relu2(d[31:0]),  last: 1'b0});
        q.push_back('{data: relu2(d[63:32]), last: l});
        if (l) in_lasts++;
      end
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    s_if.valid = 1'b0;
    $display("beat in data=%h last=%0b", d, l);
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && q.size() > 0; c++) @(negedge clk);
    check("drain_empty", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each output handshake against the scoreboard, and check stall stability.
  logic        stall_prev = 0;
  logic [31:0] prev_data;
  logic        prev_last;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev && m_if.valid) begin
        check("stall_data", 64'(m_if.data), 64'(prev_data));
        check("stall_last", 64'(m_if.last), 64'(prev_last));
      end
      if (m_if.valid && m_if.ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", 64'(m_if.data), 64'hDEAD);
        end else begin
          e = q.pop_front();
          check("out_data", 64'(m_if.data), 64'(e.data));
          check("out_last", 64'(m_if.last), 64'(e.last));
          if (!rand_run) $display("sub-beat out data=%h last=%0b", m_if.data, m_if.last);
        end
        if (m_if.last) out_lasts++;
      end
      stall_prev = m_if.valid && !m_if.ready;
      prev_data  = m_if.data;
      prev_last  = m_if.last;
    end
  end

  // Random downstream backpressure during the soak phase.
  always @(posedge clk) begin
    if (rand_run) begin
      #1;
      m_if.ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  logic [31:0] d0;

  initial begin
    rst        = 1'b1;
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    s_if.data  = '0;
    m_if.ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_m_valid", 64'(m_if.valid), 64'd0);
    check("rst_m_last",  64'(m_if.last),  64'd0);
    check("rst_m_data",  64'(m_if.data),  64'd0);
    check("rst_s_ready", 64'(s_if.ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single beat, full throughput
    m_if.ready = 1'b1;
    send_beat(64'h0004_0003_0002_0001, 1'b1);
    check("latency_valid", 64'(m_if.valid), 64'd1);
    check("first_sub",     64'(m_if.data),  64'h0002_0001);
    check("first_last",    64'(m_if.last),  64'd0);
    @(posedge clk);
    #1;
    check("second_sub",    64'(m_if.data),  64'h0004_0003);
    check("second_last",   64'(m_if.last),  64'd1);
    drain();

    // Back-to-back beats: four valid cycles, refill at cnt=1
    fork
      begin
        send_beat(64'h0014_0013_0012_0011, 1'b0);
        send_beat(64'h0024_0023_0022_0021, 1'b1);
      end
      begin
        for (int c = 0; c < 20 && !m_if.valid; c++) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          check("b2b_valid", 64'(m_if.valid), 64'd1);
          if (i == 1) check("b2b_sready_cnt1", 64'(s_if.ready), 64'd1);
          @(negedge clk);
        end
      end
    join
    drain();

    // Backpressure during sub-beat 0
    m_if.ready = 1'b0;
    send_beat(64'h0034_0033_0032_0031, 1'b1);
    d0 = m_if.data;
    check("stall_first", 64'(d0), 64'h0032_0031);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_hold",    64'(m_if.data),  64'(d0));
      check("stall_sready",  64'(s_if.ready), 64'd0);
      check("stall_valid",   64'(m_if.valid), 64'd1);
    end
    @(posedge clk);
    #1;
    m_if.ready = 1'b1;
    drain();

    // Reset while cnt=1 discards the held beat
    send_beat(64'h0044_0043_0042_0041, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    in_lasts = 0;
    #1;
    check("midrst_m_valid", 64'(m_if.valid), 64'd0);
    check("midrst_s_ready", 64'(s_if.ready), 64'd1);
    check("midrst_m_data",  64'(m_if.data),  64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_lasts = 0;
    send_beat(64'h0054_0053_0052_0051, 1'b1);
    check("postrst_first", 64'(m_if.data), 64'h0052_0051);
    drain();

    // Negative lanes: clamped with ReLU, bit-exact otherwise
    send_beat(64'h1234_7FFF_8000_FFF0, 1'b0);
`ifdef AXIS_SA_DW_RELU_EN
    check("relu_neg", 64'(m_if.data), 64'h0000_0000);
`else
    check("relu_neg", 64'(m_if.data), 64'h8000_FFF0);
`endif
    @(posedge clk);
    #1;
    check("relu_pos", 64'(m_if.data), 64'h1234_7FFF);
    drain();

    // Random valid/ready soak
    in_lasts  = 0;
    out_lasts = 0;
    rand_run  = 1;
    for (int b = 0; b < 300; b++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send_beat({$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
    end
    rand_run = 0;
    #2;
    m_if.ready = 1'b1;
    drain();
    check("last_count", 64'(out_lasts), 64'(in_lasts));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
